// File: rtl/spi_target_if.sv
// SPI pin bundle plus register-write and status sideband for spi_target.
// The target takes the slave modport and the controller/bench takes the master modport.
interface spi_target_if;
  logic       sclk_i;
  logic       cs_n_i;
  logic       mosi_i;
  logic       miso_o;
  logic       wr_valid_o;
  logic [6:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic       rd_done_o;
  logic       err_o;
  logic       busy_o;

  modport slave (
    input  sclk_i, cs_n_i, mosi_i,
    output miso_o, wr_valid_o, wr_addr_o, wr_data_o, rd_done_o, err_o, busy_o
  );

  modport master (
    output sclk_i, cs_n_i, mosi_i,
    input  miso_o, wr_valid_o, wr_addr_o, wr_data_o, rd_done_o, err_o, busy_o
  );
endinterface

// File: rtl/spi_target.sv
// SPI register target, oversampled by pclk_i: an LSB-first address byte (bit7 = write)
// followed by a data byte that is either written into or read out of a small register file.
module spi_target #(
  parameter int NUM_REGS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         pclk_i,
  input  logic         prst_i,
  spi_target_if.slave  bus
);
  localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int         DEPTH      = 1 << AW;
  localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WDATA, S_RDATA} state_t;

  state_t     state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic [7:0] addr_reg, addr_next;
  logic [7:0] data_reg, data_next;
  logic [7:0] rd_data_reg, rd_data_next;
  logic       miso_reg, miso_next;
  logic       do_write, rd_done_next, err_next;

  logic       wr_valid_reg, rd_done_reg, err_reg;
  logic [6:0] wr_addr_reg;
  logic [7:0] wr_data_reg;
  logic [7:0] regs_reg [DEPTH];

  // Each stage holds {sclk, cs_n, mosi}; all three travel through the same depth.
  logic [SYNC_STAGES-1:0][2:0] sync_reg;
  logic sclk_prev_reg;
  logic sclk_s, cs_s, mosi_s, fall;

  assign sclk_s = sync_reg[SYNC_STAGES-1][2];
  assign cs_s   = sync_reg[SYNC_STAGES-1][1];
  assign mosi_s = sync_reg[SYNC_STAGES-1][0];
  assign fall   = sclk_prev_reg & ~sclk_s;

  function automatic logic in_range(input logic [6:0] a);
    return {1'b0, a} < NUM_REGS_B;
  endfunction

  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    addr_next    = addr_reg;
    data_next    = data_reg;
    rd_data_next = rd_data_reg;
    miso_next    = miso_reg;
    do_write     = 1'b0;
    rd_done_next = 1'b0;
    err_next     = 1'b0;

    if (state_reg == S_IDLE) begin
      if (!cs_s) begin
        state_next = S_ADDR;
        cnt_next   = 3'd0;
      end
    end else if (cs_s) begin
      // Controller deselected mid-frame: drop everything collected so far.
      state_next   = S_IDLE;
      cnt_next     = 3'd0;
      addr_next    = 8'h00;
      data_next    = 8'h00;
      rd_data_next = 8'h00;
      miso_next    = 1'b1;
    end else if (fall) begin
      cnt_next = cnt_reg + 3'd1;
      unique case (state_reg)
        S_ADDR: begin
          addr_next[cnt_reg] = mosi_s;
          if (cnt_reg == 3'd7) begin
            if (addr_next[7]) begin
              state_next = S_WDATA;
            end else begin
              state_next   = S_RDATA;
              rd_data_next = in_range(addr_next[6:0]) ? regs_reg[addr_next[AW-1:0]] : 8'hFF;
              miso_next    = rd_data_next[0];
            end
          end
        end
        S_WDATA: begin
          data_next[cnt_reg] = mosi_s;
          if (cnt_reg == 3'd7) begin
            state_next = S_ADDR;
            do_write   = in_range(addr_reg[6:0]);
            err_next   = ~in_range(addr_reg[6:0]);
          end
        end
        S_RDATA: begin
          if (cnt_reg == 3'd7) begin
            state_next   = S_ADDR;
            miso_next    = 1'b1;
            rd_done_next = 1'b1;
            err_next     = ~in_range(addr_reg[6:0]);
          end else begin
            miso_next = rd_data_reg[cnt_next];
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      sync_reg      <= '1;
      sclk_prev_reg <= 1'b1;
      addr_reg      <= 8'h00;
      data_reg      <= 8'h00;
      rd_data_reg   <= 8'h00;
      miso_reg      <= 1'b1;
      wr_valid_reg  <= 1'b0;
      wr_addr_reg   <= 7'h00;
      wr_data_reg   <= 8'h00;
      rd_done_reg   <= 1'b0;
      err_reg       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs_reg[i] <= 8'h00;
    end else begin
      sync_reg[0] <= {bus.sclk_i, bus.cs_n_i, bus.mosi_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
      sclk_prev_reg <= sclk_s;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      rd_data_reg   <= rd_data_next;
      miso_reg      <= miso_next;
      wr_valid_reg  <= do_write;
      rd_done_reg   <= rd_done_next;
      err_reg       <= err_next;
      if (do_write) begin
        regs_reg[addr_reg[AW-1:0]] <= data_next;
        wr_addr_reg                <= addr_reg[6:0];
        wr_data_reg                <= data_next;
      end
    end
  end

  assign bus.miso_o     = miso_reg;
  assign bus.wr_valid_o = wr_valid_reg;
  assign bus.wr_addr_o  = wr_addr_reg;
  assign bus.wr_data_o  = wr_data_reg;
  assign bus.rd_done_o  = rd_done_reg;
  assign bus.err_o      = err_reg;
  assign bus.busy_o     = (state_reg != S_IDLE);
endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: directed frames plus random frames compared
// against a byte-array model of the register file.
module tb_spi_target;
  localparam int NUM_REGS = 8;
  localparam int HALF     = 8;

  logic pclk = 1'b0;
  logic prst = 1'b0;
  always #5 pclk = ~pclk;

  spi_target_if bus ();

  spi_target #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(2)) dut (
    .pclk_i (pclk),
    .prst_i (prst),
    .bus    (bus)
  );

  int checks = 0;
  int passed = 0;
  logic [7:0] model [NUM_REGS];

  int         n_wr = 0, n_rd = 0, n_err = 0, bad_pulse = 0;
  logic [6:0] last_wr_addr = '0;
  logic [7:0] last_wr_data = '0;
  logic       wr_prev = 0, rd_prev = 0, err_prev = 0;

  // Pulse counter and pulse-shape watcher, sampled away from the active edge.
  always @(negedge pclk) begin
    if (prst) begin
      if (bus.wr_valid_o) begin
        n_wr++;
        last_wr_addr = bus.wr_addr_o;
        last_wr_data = bus.wr_data_o;
      end
      if (bus.rd_done_o) n_rd++;
      if (bus.err_o) n_err++;
      if ((bus.wr_valid_o && wr_prev) || (bus.rd_done_o && rd_prev) || (bus.err_o && err_prev))
        bad_pulse++;
      if (bus.wr_valid_o && (bus.rd_done_o || bus.err_o)) bad_pulse++;
      if (bus.err_o && !bus.rd_done_o && bus.wr_valid_o) bad_pulse++;
    end
    wr_prev  = bus.wr_valid_o;
    rd_prev  = bus.rd_done_o;
    err_prev = bus.err_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_pclk(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // Clocks out nbits of tx LSB first; miso is sampled just before each falling edge.
  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi_i = tx[i];
      wait_pclk(HALF);
      rx[i] = bus.miso_o;
      bus.sclk_i = 1'b0;
      wait_pclk(HALF);
      bus.sclk_i = 1'b1;
    end
  endtask

  task automatic check_frame(input logic [7:0] a, input logic [7:0] d, input bit keep_cs,
                             input int gap);
    logic [7:0] rx, dummy, exp_rx;
    int wr0, rd0, err0;
    bit is_wr, inr;
    is_wr  = a[7];
    inr    = (int'(a[6:0]) < NUM_REGS);
    exp_rx = (!is_wr && inr) ? model[a[2:0]] : 8'hFF;
    wr0 = n_wr; rd0 = n_rd; err0 = n_err;
    if (bus.cs_n_i) begin
      bus.cs_n_i = 1'b0;
      wait_pclk(HALF);
    end
    xfer_bits(a, 8, dummy);
    wait_pclk(2 * HALF * gap);
    xfer_bits(d, 8, rx);
    wait_pclk(HALF);
    if (!keep_cs) begin
      bus.cs_n_i = 1'b1;
      wait_pclk(HALF);
    end
    $display("frame addr=%02h data=%02h rx=%02h wr=%0d rd=%0d err=%0d", a, d, rx,
             n_wr - wr0, n_rd - rd0, n_err - err0);
    check("wr_pulses", n_wr - wr0, (is_wr && inr) ? 1 : 0);
    check("rd_pulses", n_rd - rd0, is_wr ? 0 : 1);
    check("err_pulses", n_err - err0, inr ? 0 : 1);
    check("miso_byte", rx, exp_rx);
    if (is_wr && inr) begin
      check("wr_addr", last_wr_addr, a[6:0]);
      check("wr_data", last_wr_data, d);
      model[a[2:0]] = d;
    end
    if (!keep_cs) check("busy_after", bus.busy_o, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, bus.miso_o, 1'b1);
    check({tag, "_wr_valid"}, bus.wr_valid_o, 1'b0);
    check({tag, "_rd_done"}, bus.rd_done_o, 1'b0);
    check({tag, "_err"}, bus.err_o, 1'b0);
    check({tag, "_busy"}, bus.busy_o, 1'b0);
    check({tag, "_wr_addr"}, bus.wr_addr_o, 7'h00);
    check({tag, "_wr_data"}, bus.wr_data_o, 8'h00);
  endtask

  initial begin
    logic [7:0] dummy;
    int wr0, rd0, err0;
    bus.sclk_i = 1'b1;
    bus.cs_n_i = 1'b1;
    bus.mosi_i = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;

    // Reset state
    wait_pclk(4);
    check_reset_outputs("reset");
    prst = 1'b1;
    wait_pclk(4);
    check_reset_outputs("post_reset");

    // Write, read-back, out-of-range write and read
    check_frame(8'h83, 8'hA5, 0, 4);
    check_frame(8'h03, 8'h00, 0, 1);
    check_frame(8'h8A, 8'h11, 0, 1);
    check_frame(8'h0A, 8'h00, 0, 0);
    check("idle_miso", bus.miso_o, 1'b1);

    // Abort a write to addr 2 after 5 data bits
    check_frame(8'h82, 8'h77, 0, 1);
    wr0 = n_wr; rd0 = n_rd; err0 = n_err;
    bus.cs_n_i = 1'b0;
    wait_pclk(HALF);
    xfer_bits(8'h82, 8, dummy);
    wait_pclk(2 * HALF);
    xfer_bits(8'h5A, 5, dummy);
    bus.cs_n_i = 1'b1;
    wait_pclk(2 * HALF);
    $display("abort addr=02 after 5 bits busy=%0d", bus.busy_o);
    check("abort_busy", bus.busy_o, 1'b0);
    check("abort_miso", bus.miso_o, 1'b1);
    check("abort_pulses", (n_wr - wr0) + (n_rd - rd0) + (n_err - err0), 0);
    check_frame(8'h02, 8'h00, 0, 1);

    // Back-to-back frames with cs_n held low
    for (int i = 0; i < 8; i++) check_frame(8'h80 | 8'(i), 8'h10 + 8'(i), 1, 1);
    for (int i = 0; i < 8; i++) check_frame(8'(i), 8'h00, (i != 7), 0);

    // Random frames, including out-of-range addresses and random gaps
    for (int n = 0; n < 24; n++) begin
      logic [7:0] a;
      a = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 11))};
      check_frame(a, 8'($urandom), (n != 23) && ($urandom_range(0, 1) == 1), $urandom_range(0, 3));
    end

    // Reset asserted during the address phase
    bus.cs_n_i = 1'b0;
    wait_pclk(HALF);
    xfer_bits(8'h81, 4, dummy);
    prst = 1'b0;
    #1;
    $display("reset mid-address busy=%0d miso=%0d", bus.busy_o, bus.miso_o);
    check_reset_outputs("mid_reset");
    for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
    bus.cs_n_i = 1'b1;
    bus.sclk_i = 1'b1;
    wait_pclk(4);
    prst = 1'b1;
    wait_pclk(4);
    check_frame(8'h81, 8'h3C, 0, 2);
    check_frame(8'h01, 8'h00, 0, 1);
    check_frame(8'h04, 8'h00, 0, 1);

    check("pulse_shape", bad_pulse, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, number of 8-bit target registers (addresses 0..NUM_REGS-1).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on sclk_i, cs_n_i and mosi_i.
REQ-003 pclk_i  input  1  sole clock, all logic rising-edge.
REQ-004 prst_i  input  1  reset, asynchronous, active-low.
REQ-005 sclk_i  input  1  SPI serial clock from controller, idle high, asynchronous to pclk_i.
REQ-006 cs_n_i  input  1  chip select, active-low, asynchronous.
REQ-007 mosi_i  input  1  serial data from controller, LSB first.
REQ-008 miso_o  output  1  serial read data to controller, LSB first, idle high.
REQ-009 wr_valid_o  output  1  one-cycle pulse: a register write completed.
REQ-010 wr_addr_o  output  7  address of the completed write, valid with wr_valid_o.
REQ-011 wr_data_o  output  8  data of the completed write, valid with wr_valid_o.
REQ-012 rd_done_o  output  1  one-cycle pulse: a read frame completed.
REQ-013 err_o  output  1  one-cycle pulse: out-of-range address completed a transfer.
REQ-014 busy_o  output  1  high in every state except S_IDLE.

Function
REQ-015 SHALL synchronize sclk_i, cs_n_i and mosi_i through SYNC_STAGES flops each and use only the synchronized copies; pclk_i frequency SHALL be at least 8x sclk_i frequency.
REQ-016 SHALL detect an sclk falling edge as synchronized sclk going 1->0 between consecutive pclk cycles; mosi SHALL be sampled on that edge.
REQ-017 Frame format SHALL be: address byte (8 falling edges, bit0 first), any idle gap with sclk high, data byte (8 falling edges, bit0 first).
REQ-018 Address byte bit7 SHALL select direction: 1 = write (controller drives mosi), 0 = read (target drives miso); bits [6:0] = register address.
REQ-019 States: S_IDLE, S_ADDR, S_WDATA, S_RDATA.
REQ-020 S_IDLE -> S_ADDR when synchronized cs_n is low; bit counter cleared.
REQ-021 S_ADDR: shift in one bit per falling edge; on 8th edge go to S_WDATA (bit7=1) or S_RDATA (bit7=0), counter cleared.
REQ-022 On entry to S_RDATA, miso_o SHALL present bit0 of reg[addr] within 1 pclk of the 8th address edge being detected; each subsequent data-phase falling edge SHALL advance miso_o to the next bit.
REQ-023 S_WDATA: shift in one bit per falling edge; on 8th edge, if addr < NUM_REGS, write reg[addr] and pulse wr_valid_o with wr_addr_o/wr_data_o in the following cycle.
REQ-024 S_RDATA: on 8th falling edge pulse rd_done_o; miso_o returns to 1.
REQ-025 After 8th data edge SHALL go to S_ADDR if cs_n low, else S_IDLE; back-to-back frames with cs_n held low SHALL be accepted.
REQ-026 Address >= NUM_REGS: write SHALL be discarded (no wr_valid_o), read SHALL return 8'hFF; err_o SHALL pulse at the 8th data edge.
REQ-027 cs_n rising mid-frame SHALL abort: go to S_IDLE, clear counter and shift registers, no write, no pulses, miso_o = 1.
REQ-028 Idle gap length between address and data SHALL be unbounded; state and counter SHALL hold while no falling edge occurs.
REQ-029 Output pulses SHALL be exactly one pclk wide and never simultaneous with each other, except err_o with rd_done_o on an out-of-range read.

Reset
REQ-030 prst_i low SHALL asynchronously force: state S_IDLE, counter 0, all registers 8'h00, synchronizers to idle (sclk 1, cs_n 1, mosi 1), miso_o 1, wr_valid_o/rd_done_o/err_o/busy_o 0, wr_addr_o 0, wr_data_o 0.
REQ-031 Reset asserted mid-frame SHALL discard the frame; first frame after release SHALL decode normally.

Verification
REQ-032 Write: cs_n low, addr 8'h83, gap 4 sclk, data 8'hA5 -> wr_valid_o pulse, wr_addr_o 7'h03, wr_data_o 8'hA5, reg[3]=8'hA5.
REQ-033 Read-back: after REQ-032, addr 8'h03, data phase -> miso_o bits LSB first 1,0,1,0,0,1,0,1, rd_done_o pulse.
REQ-034 Out-of-range: addr 8'h8A data 8'h11 -> no wr_valid_o, err_o pulse; addr 8'h0A read -> miso 8'hFF, err_o and rd_done_o pulse.
REQ-035 Abort: cs_n raised after 5 data bits of write to addr 2 -> reg[2] unchanged, busy_o 0, no pulses.
REQ-036 Back-to-back: cs_n held low, writes to addr 0..7 with data 8'h10..8'h17 -> 8 wr_valid_o pulses, reads return matching values.
REQ-037 Reset: prst_i low during address phase -> all outputs at REQ-030 values immediately; following write to addr 1 succeeds.
